// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped WIDTH times, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for two's-complement subtraction.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; the caller's cin has no meaning here.
    assign b_load = sub ? ~b : b;
    assign c_load = sub | cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign last = (cnt == CW'(WIDTH - 1));
    assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    // Result registers move only here, so partial sums stay hidden.
                    if (last) begin
                        sum  <= {fa_s, s_sr[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): timing, arithmetic, start-held, mid-run reset.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_assert = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation: pulse start, scramble operands after acceptance,
    // then check busy window, done pulse and final result.
    task automatic run_op(input string tag,
                          input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                          input logic [7:0] es, input logic ec,
                          input logic [7:0] ps, input logic pc);
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = 8'hA5; cin = ~tcin;
        for (int i = 0; i < 8; i++) begin
            check1({tag, " busy"}, busy, 1'b1);
            check1({tag, " done early"}, done, 1'b0);
            check8({tag, " sum held"}, sum, ps);
            check1({tag, " cout held"}, cout, pc);
            @(negedge clk);
        end
        check1({tag, " busy end"}, busy, 1'b0);
        check1({tag, " done"}, done, 1'b1);
        check8({tag, " sum"}, sum, es);
        check1({tag, " cout"}, cout, ec);
        @(negedge clk);
        check1({tag, " done width"}, done, 1'b0);
        check8({tag, " sum kept"}, sum, es);
        check1({tag, " cout kept"}, cout, ec);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check1("reset busy", busy, 1'b0);
        check1("reset done", done, 1'b0);
        check8("reset sum", sum, 8'h00);
        check1("reset cout", cout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check1("idle busy", busy, 1'b0);

        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h00, 1'b0);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0);
        run_op("addffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1);
        run_op("add8080", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 8'hFF, 1'b1);

        // start held high: accepts at k=-1 edge (E0), k=9 and k=19 operands
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check1("held busy", busy, (k % 10) < 8);
            check1("held done", done, (k % 10) == 8);
            if (k == 8) begin
                check8("held sum0", sum, 8'h33);
                check1("held cout0", cout, 1'b0);
            end
            if (k == 18) begin
                check8("held sum1", sum, 8'hB8);
                check1("held cout1", cout, 1'b0);
            end
            if (k == 28) begin
                check8("held sum2", sum, 8'h80);
                check1("held cout2", cout, 1'b1);
            end
            a = 8'(k * 7 + 3);
            b = 8'(k * 13 + 1);
            if (k == 29) start = 1'b0;
        end
        @(negedge clk);
        check1("held stop busy", busy, 1'b0);

        // reset asserted for the E0+4 edge of an active add
        a = 8'h5A; b = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check1("pre-abort busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check1("abort busy", busy, 1'b0);
        check1("abort done", done, 1'b0);
        check8("abort sum", sum, 8'h00);
        check1("abort cout", cout, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check1("abort no done", done, 1'b0);
        end
        run_op("after abort", 8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub10-01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 8'h11, 1'b0);
        run_op("sub00-01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 8'h0F, 1'b1);
        run_op("sub cin ign", 8'h20, 8'h05, 1'b1, 8'h1B, 1'b1, 8'hFF, 1'b0);
        sub = 1'b0;
        run_op("add after sub", 8'h20, 8'h05, 1'b1, 8'h26, 1'b0, 8'h1B, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
